// File: rtl/layer_scheduler.sv
// Per-layer tile scheduler: for each output tile runs READ -> COMP -> WRITE, driving
// buffer reads, launching the PE array and handing results on. Optional port: SCHED_ABORT_EN.
module layer_scheduler #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned TILE_W = 8,
  parameter int unsigned WIN    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        layer_mode,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic              pe_done,
  input  logic              wr_ready,
`ifdef SCHED_ABORT_EN
  input  logic              abort,
`endif
  output logic              ifm_read,
  output logic              wgt_read,
  output logic              bias_read,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              pe_start,
  output logic              wr_valid,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned K_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned P_W = ADDR_W + TILE_W;
  localparam logic [K_W-1:0] K_LAST = K_W'(WIN - 1);

  localparam logic [1:0] MODE_CONV = 2'b01;
  localparam logic [1:0] MODE_FC   = 2'b11;

  typedef enum logic [2:0] {IDLE, READ, COMP, WRITE, NEXT, FINISH} state_t;

  state_t            state, state_n;
  logic              launch;
  logic [K_W-1:0]    k, k_n;
  logic [TILE_W-1:0] tile_n;
  logic [1:0]        mode_q;
  logic [TILE_W-1:0] ntiles_q;
  logic [ADDR_W-1:0] ifm_base_q, wgt_base_q;

  logic              accept;
  logic [P_W-1:0]    prod_n;
  logic [ADDR_W-1:0] tile_off_n;
  logic [ADDR_W-1:0] ifm_addr_n, wgt_addr_n;
  logic              rd_n, wgt_read_n, bias_read_n, pe_start_n;

  assign accept = (state == IDLE) && !launch && start && (layer_mode != 2'b00);

  // An accepted start spends one cycle in IDLE (launch) so that every output,
  // registered from next-state values, shows the first read beat after edge 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      launch     <= 1'b0;
      k          <= '0;
      tile_idx   <= '0;
      mode_q     <= '0;
      ntiles_q   <= '0;
      ifm_base_q <= '0;
      wgt_base_q <= '0;
    end else begin
      state    <= state_n;
      launch   <= accept;
      k        <= k_n;
      tile_idx <= tile_n;
      if (accept) begin
        mode_q     <= layer_mode;
        ntiles_q   <= num_tiles;
        ifm_base_q <= ifm_base;
        wgt_base_q <= wgt_base;
      end
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    tile_n  = tile_idx;
    unique case (state)
      IDLE: begin
        if (launch) begin
          tile_n  = '0;
          k_n     = '0;
          state_n = (ntiles_q == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (k == K_LAST) state_n = COMP;
        else             k_n     = k + K_W'(1);
      end
      COMP: begin
        if (pe_done) state_n = WRITE;
      end
      WRITE: begin
        if (wr_ready) state_n = NEXT;
      end
      NEXT: begin
        if (tile_idx == ntiles_q - TILE_W'(1)) begin
          state_n = FINISH;
        end else begin
          tile_n  = tile_idx + TILE_W'(1);
          k_n     = '0;
          state_n = READ;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef SCHED_ABORT_EN
    if (abort && (state != IDLE)) state_n = IDLE;
`endif
  end

  // Output values for the upcoming cycle, derived from the next state.
  always_comb begin
    prod_n      = P_W'(tile_n) * P_W'(WIN);
    tile_off_n  = prod_n[ADDR_W-1:0];
    ifm_addr_n  = ifm_base_q + tile_off_n + ADDR_W'(k_n);
    wgt_addr_n  = '0;
    if (mode_q == MODE_CONV)    wgt_addr_n = wgt_base_q + ADDR_W'(k_n);
    else if (mode_q == MODE_FC) wgt_addr_n = wgt_base_q + tile_off_n + ADDR_W'(k_n);
    rd_n        = (state_n == READ);
    bias_read_n = rd_n && (mode_q == MODE_CONV) && (k_n == '0);
    wgt_read_n  = rd_n && ((mode_q == MODE_FC) || ((mode_q == MODE_CONV) && (k_n == '0)));
    pe_start_n  = (state_n == COMP) && (state != COMP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifm_read  <= 1'b0;
      wgt_read  <= 1'b0;
      bias_read <= 1'b0;
      ifm_addr  <= '0;
      wgt_addr  <= '0;
      pe_start  <= 1'b0;
      wr_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ifm_read  <= rd_n;
      wgt_read  <= wgt_read_n;
      bias_read <= bias_read_n;
      if (rd_n) begin
        ifm_addr <= ifm_addr_n;
        wgt_addr <= wgt_addr_n;
      end
      pe_start  <= pe_start_n;
      wr_valid  <= (state_n == WRITE);
      busy      <= (state_n != IDLE);
      done      <= (state_n == FINISH);
      err       <= (state == IDLE) && !launch && start && (layer_mode == 2'b00);
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed self-checking bench for layer_scheduler (default build; abort test
// is included when SCHED_ABORT_EN is defined).
module tb_layer_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  layer_mode;
  logic [7:0]  num_tiles;
  logic [11:0] ifm_base, wgt_base;
  logic        pe_done, wr_ready;
  logic        ifm_read, wgt_read, bias_read;
  logic [11:0] ifm_addr, wgt_addr;
  logic        pe_start, wr_valid, busy, done, err;
  logic [7:0]  tile_idx;
`ifdef SCHED_ABORT_EN
  logic        abort;
`endif

  logic [39:0] outs;
  assign outs = {ifm_read, wgt_read, bias_read, pe_start, wr_valid, busy, done, err,
                 ifm_addr, wgt_addr, tile_idx};

  int checks = 0;
  int errors = 0;

  logic [11:0] ifm_log [0:63];
  logic [11:0] wa_log  [0:63];
  logic        wr_log  [0:63];
  logic        br_log  [0:63];
  int n_beats, n_pe, n_done, n_err, n_xfer, done_cyc;
  logic busy_after;

  layer_scheduler #(.ADDR_W(12), .TILE_W(8), .WIN(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer_mode(layer_mode),
    .num_tiles(num_tiles), .ifm_base(ifm_base), .wgt_base(wgt_base),
    .pe_done(pe_done), .wr_ready(wr_ready),
`ifdef SCHED_ABORT_EN
    .abort(abort),
`endif
    .ifm_read(ifm_read), .wgt_read(wgt_read), .bias_read(bias_read),
    .ifm_addr(ifm_addr), .wgt_addr(wgt_addr), .pe_start(pe_start),
    .wr_valid(wr_valid), .tile_idx(tile_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one layer and logs what happened; cycle c is the period after edge c,
  // where edge 0 samples start. A second start is offered at restart_cyc.
  task automatic run_layer(input logic [1:0] mode, input logic [7:0] nt,
                           input logic [11:0] ib, input logic [11:0] wb,
                           input int pd_delay, input int restart_cyc);
    int pd_cnt;
    n_beats = 0; n_pe = 0; n_done = 0; n_err = 0; n_xfer = 0;
    done_cyc = -1; busy_after = 1'b1; pd_cnt = -1;
    @(negedge clk);
    layer_mode = mode; num_tiles = nt; ifm_base = ib; wgt_base = wb;
    wr_ready = 1'b1; pe_done = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (ifm_read && n_beats < 64) begin
        ifm_log[n_beats] = ifm_addr;
        wa_log[n_beats]  = wgt_addr;
        wr_log[n_beats]  = wgt_read;
        br_log[n_beats]  = bias_read;
      end
      if (ifm_read) n_beats++;
      if (pe_start) begin n_pe++; pd_cnt = pd_delay; end
      pe_done = 1'b0;
      if (pd_cnt == 0) pe_done = 1'b1;
      if (pd_cnt >= 0) pd_cnt--;
      if (wr_valid && wr_ready) n_xfer++;
      if (err) n_err++;
      if (done_cyc >= 0 && c == done_cyc + 1) begin busy_after = busy; break; end
      if (done) begin n_done++; done_cyc = c; end
      start = (c == restart_cyc);
      if (c == restart_cyc) begin
        layer_mode = 2'b00; num_tiles = 8'd5; ifm_base = 12'h300; wgt_base = 12'h3A0;
      end
      @(negedge clk);
    end
    start = 1'b0; pe_done = 1'b0;
    checks++;
    if (done_cyc < 0) begin errors++; $display("FAIL run_timeout: no done within budget"); end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (outs !== 40'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 40'h0) begin errors++; $display("FAIL idle_outputs: got %h want 0", outs); end
  endtask

  task automatic test_conv;
    logic [11:0] exp;
    run_layer(2'b01, 8'd2, 12'h100, 12'h040, 3, -1);
    checks++;
    if (n_beats !== 18) begin errors++; $display("FAIL conv_beats: got %0d want 18", n_beats); end
    for (int b = 0; b < 18; b++) begin
      exp = 12'h100 + 12'(b);
      checks++;
      if (ifm_log[b] !== exp) begin errors++; $display("FAIL conv_ifm_addr[%0d]: got %h want %h", b, ifm_log[b], exp); end
      checks++;
      if (br_log[b] !== (b % 9 == 0)) begin errors++; $display("FAIL conv_bias[%0d]: got %b", b, br_log[b]); end
      checks++;
      if (wr_log[b] !== (b % 9 == 0)) begin errors++; $display("FAIL conv_wgt_read[%0d]: got %b", b, wr_log[b]); end
      exp = 12'h040 + 12'(b % 9);
      checks++;
      if (wa_log[b] !== exp) begin errors++; $display("FAIL conv_wgt_addr[%0d]: got %h want %h", b, wa_log[b], exp); end
    end
    checks++;
    if (n_pe !== 2) begin errors++; $display("FAIL conv_pe_start: got %0d want 2", n_pe); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL conv_done_count: got %0d want 1", n_done); end
    checks++;
    if (done_cyc !== 31) begin errors++; $display("FAIL conv_done_cycle: got %0d want 31", done_cyc); end
    checks++;
    if (n_xfer !== 2) begin errors++; $display("FAIL conv_xfers: got %0d want 2", n_xfer); end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL conv_busy_after: got %b want 0", busy_after); end
    checks++;
    if (tile_idx !== 8'd1) begin errors++; $display("FAIL conv_tile_hold: got %0d want 1", tile_idx); end
  endtask

  task automatic test_pool;
    logic [11:0] exp;
    run_layer(2'b10, 8'd1, 12'h200, 12'h055, 0, -1);
    checks++;
    if (n_beats !== 9) begin errors++; $display("FAIL pool_beats: got %0d want 9", n_beats); end
    for (int b = 0; b < 9; b++) begin
      exp = 12'h200 + 12'(b);
      checks++;
      if (ifm_log[b] !== exp) begin errors++; $display("FAIL pool_ifm_addr[%0d]: got %h want %h", b, ifm_log[b], exp); end
      checks++;
      if ({wr_log[b], br_log[b]} !== 2'b00) begin errors++; $display("FAIL pool_wgt_bias[%0d]: got %b%b want 00", b, wr_log[b], br_log[b]); end
      checks++;
      if (wa_log[b] !== 12'h000) begin errors++; $display("FAIL pool_wgt_addr[%0d]: got %h want 000", b, wa_log[b]); end
    end
    checks++;
    if (done_cyc !== 13) begin errors++; $display("FAIL pool_min_period: got %0d want 13", done_cyc); end
  endtask

  task automatic test_fc;
    logic [11:0] exp;
    run_layer(2'b11, 8'd2, 12'h000, 12'h000, 0, -1);
    checks++;
    if (n_beats !== 18) begin errors++; $display("FAIL fc_beats: got %0d want 18", n_beats); end
    for (int b = 0; b < 18; b++) begin
      exp = 12'(b);
      checks++;
      if (wa_log[b] !== exp) begin errors++; $display("FAIL fc_wgt_addr[%0d]: got %h want %h", b, wa_log[b], exp); end
      checks++;
      if ({wr_log[b], br_log[b]} !== 2'b10) begin errors++; $display("FAIL fc_wgt_bias[%0d]: got %b%b want 10", b, wr_log[b], br_log[b]); end
    end
    checks++;
    if (done_cyc !== 25) begin errors++; $display("FAIL fc_done_cycle: got %0d want 25", done_cyc); end
  endtask

  task automatic test_wrap;
    logic [11:0] exp;
    run_layer(2'b01, 8'd1, 12'hFFC, 12'h010, 1, -1);
    checks++;
    if (n_beats !== 9) begin errors++; $display("FAIL wrap_beats: got %0d want 9", n_beats); end
    for (int b = 0; b < 9; b++) begin
      exp = 12'hFFC + 12'(b);
      checks++;
      if (ifm_log[b] !== exp) begin errors++; $display("FAIL wrap_ifm_addr[%0d]: got %h want %h", b, ifm_log[b], exp); end
    end
    checks++;
    if (done_cyc !== 14) begin errors++; $display("FAIL wrap_done_cycle: got %0d want 14", done_cyc); end
  endtask

  task automatic test_zero_tiles;
    run_layer(2'b01, 8'd0, 12'h100, 12'h040, 0, -1);
    checks++;
    if (n_beats !== 0) begin errors++; $display("FAIL zero_beats: got %0d want 0", n_beats); end
    checks++;
    if (done_cyc !== 1) begin errors++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
    checks++;
    if (n_pe !== 0) begin errors++; $display("FAIL zero_pe_start: got %0d want 0", n_pe); end
    checks++;
    if (busy_after !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %b want 0", busy_after); end
  endtask

  task automatic test_illegal_mode;
    @(negedge clk);
    layer_mode = 2'b00; num_tiles = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({err, busy} !== 2'b10) begin errors++; $display("FAIL err_pulse: got err=%b busy=%b want 1,0", err, busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({err, busy, ifm_read} !== 3'b000) begin errors++; $display("FAIL err_after[%0d]: got %b want 000", i, {err, busy, ifm_read}); end
    end
  endtask

  task automatic test_restart_ignored;
    logic [11:0] exp;
    run_layer(2'b10, 8'd1, 12'h200, 12'h055, 0, 5);
    checks++;
    if (n_beats !== 9) begin errors++; $display("FAIL restart_beats: got %0d want 9", n_beats); end
    for (int b = 0; b < 9; b++) begin
      exp = 12'h200 + 12'(b);
      checks++;
      if (ifm_log[b] !== exp) begin errors++; $display("FAIL restart_ifm_addr[%0d]: got %h want %h", b, ifm_log[b], exp); end
    end
    checks++;
    if (n_err !== 0) begin errors++; $display("FAIL restart_err: got %0d want 0", n_err); end
    checks++;
    if (done_cyc !== 13) begin errors++; $display("FAIL restart_done_cycle: got %0d want 13", done_cyc); end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL restart_queued: busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    layer_mode = 2'b10; num_tiles = 8'd1; ifm_base = 12'h000; wr_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      pe_done = pe_start;
      if (wr_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    pe_done = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_wr_valid_timeout: wr_valid never rose"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({wr_valid, busy, ifm_read, done} !== 4'b1100) begin
        errors++; $display("FAIL bp_hold[%0d]: got %b want 1100", i, {wr_valid, busy, ifm_read, done});
      end
    end
    wr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({wr_valid, done} !== 2'b00) begin errors++; $display("FAIL bp_next: got %b want 00", {wr_valid, done}); end
    @(negedge clk);
    checks++;
    if ({done, wr_valid} !== 2'b10) begin errors++; $display("FAIL bp_done: got %b want 10", {done, wr_valid}); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    int dcount;
    seen = 1'b0; dcount = 0;
    @(negedge clk);
    layer_mode = 2'b01; num_tiles = 8'd2; ifm_base = 12'h100; wgt_base = 12'h040;
    pe_done = 1'b0; wr_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (pe_start) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_pe_start_timeout: pe_start never rose"); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 40'h0) begin errors++; $display("FAIL rst_mid_outputs: got %h want 0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    checks++;
    if (dcount !== 0) begin errors++; $display("FAIL rst_no_done: activity cycles got %0d want 0", dcount); end
  endtask

`ifdef SCHED_ABORT_EN
  task automatic test_abort;
    int dcount;
    dcount = 0;
    @(negedge clk);
    layer_mode = 2'b01; num_tiles = 8'd1; ifm_base = 12'h100; wgt_base = 12'h040;
    wr_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ifm_read !== 1'b1) begin errors++; $display("FAIL abort_pre_read: got %b want 1", ifm_read); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, ifm_read, wgt_read, bias_read, pe_start, wr_valid} !== 6'b0) begin
      errors++; $display("FAIL abort_idle: got %b want 000000", {busy, ifm_read, wgt_read, bias_read, pe_start, wr_valid});
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    checks++;
    if (dcount !== 0) begin errors++; $display("FAIL abort_no_done: activity cycles got %0d want 0", dcount); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; layer_mode = 2'b00; num_tiles = '0;
    ifm_base = '0; wgt_base = '0; pe_done = 1'b0; wr_ready = 1'b0;
`ifdef SCHED_ABORT_EN
    abort = 1'b0;
`endif
    @(negedge clk);
    test_reset;
    test_conv;
    test_pool;
    test_fc;
    test_wrap;
    test_zero_tiles;
    test_illegal_mode;
    test_restart_ignored;
    test_backpressure;
    test_reset_mid;
`ifdef SCHED_ABORT_EN
    test_abort;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
